// File: rtl/ahfp_add_seq_if.sv
// Handshake and operand/result bundle for the sequential FP adder.
// Master drives start and operands; slave returns result, done and busy.
interface ahfp_add_seq_if;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        busy;

    modport master (
        output start,
        output dataa,
        output datab,
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  dataa,
        input  datab,
        output result,
        output done,
        output busy
    );
endinterface

// File: rtl/ahfp_add_seq.sv
// Multi-cycle single-precision FP adder: bit-serial align and normalise, truncating, no NaN/Inf.
// Latency d + n + 3 enabled edges from accept; start is ignored while busy, clk_en low stalls everything.
// Backpressure: none beyond busy; a start outside IDLE is dropped, not queued.
module ahfp_add_seq #(
    parameter int ALIGN_LIMIT = 25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_en,
    ahfp_add_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_NORM  = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic        zs_q,     zs_d;
    logic        sub_q,    sub_d;
    logic [8:0]  ez_q,     ez_d;
    logic [23:0] ml_q,     ml_d;
    logic [23:0] ms_q,     ms_d;
    logic [7:0]  d_q,      d_d;
    logic [24:0] m25_q,    m25_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    // Operand unpack: a zero exponent flushes the whole operand to zero.
    logic [7:0]  exp_a, exp_b, exp_l, exp_s, d_full;
    logic [23:0] man_a, man_b, man_l, man_s;
    logic        a_ge_b;
    logic [8:0]  ez_inc;

    always_comb begin
        exp_a  = bus.dataa[30:23];
        exp_b  = bus.datab[30:23];
        man_a  = (exp_a == 8'd0) ? 24'd0 : {1'b1, bus.dataa[22:0]};
        man_b  = (exp_b == 8'd0) ? 24'd0 : {1'b1, bus.datab[22:0]};
        a_ge_b = ({exp_a, man_a} >= {exp_b, man_b});
        exp_l  = a_ge_b ? exp_a : exp_b;
        exp_s  = a_ge_b ? exp_b : exp_a;
        man_l  = a_ge_b ? man_a : man_b;
        man_s  = a_ge_b ? man_b : man_a;
        d_full = exp_l - exp_s;
        ez_inc = ez_q + 9'd1;
    end

    always_comb begin
        state_d  = state_q;
        zs_d     = zs_q;
        sub_d    = sub_q;
        ez_d     = ez_q;
        ml_d     = ml_q;
        ms_d     = ms_q;
        d_d      = d_q;
        m25_d    = m25_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    zs_d    = a_ge_b ? bus.dataa[31] : bus.datab[31];
                    sub_d   = bus.dataa[31] ^ bus.datab[31];
                    ez_d    = {1'b0, exp_l};
                    ml_d    = man_l;
                    state_d = ST_ALIGN;
                    // Far-apart exponents skip alignment entirely.
                    if (d_full > 8'(ALIGN_LIMIT)) begin
                        ms_d = 24'd0;
                        d_d  = 8'd0;
                    end else begin
                        ms_d = man_s;
                        d_d  = d_full;
                    end
                end
            end

            ST_ALIGN: begin
                if (d_q == 8'd0) begin
                    state_d = ST_ADD;
                end else begin
                    ms_d = ms_q >> 1;
                    d_d  = d_q - 8'd1;
                end
            end

            ST_ADD: begin
                m25_d   = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                                : ({1'b0, ml_q} + {1'b0, ms_q});
                state_d = ST_NORM;
            end

            ST_NORM: begin
                if (m25_q == 25'd0) begin
                    result_d = 32'h0000_0000;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (m25_q[24]) begin
                    // Carry out: one right shift always suffices; overflow saturates to Inf pattern.
                    m25_d    = m25_q >> 1;
                    ez_d     = ez_inc;
                    result_d = (ez_inc >= 9'd255) ? {zs_q, 8'hFF, 23'd0}
                                                  : {zs_q, ez_inc[7:0], m25_q[23:1]};
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (m25_q[23]) begin
                    result_d = {zs_q, ez_q[7:0], m25_q[22:0]};
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (ez_q == 9'd1) begin
                    result_d = 32'h0000_0000;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    m25_d = m25_q << 1;
                    ez_d  = ez_q - 9'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            zs_q     <= 1'b0;
            sub_q    <= 1'b0;
            ez_q     <= 9'd0;
            ml_q     <= 24'd0;
            ms_q     <= 24'd0;
            d_q      <= 8'd0;
            m25_q    <= 25'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            zs_q     <= zs_d;
            sub_q    <= sub_d;
            ez_q     <= ez_d;
            ml_q     <= ml_d;
            ms_q     <= ms_d;
            d_q      <= d_d;
            m25_q    <= m25_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahfp_add_seq.sv
// Directed bench for ahfp_add_seq: hand-computed sums and latencies, stall, back-to-back and reset cases.
module tb_ahfp_add_seq;
    logic clk;
    logic reset_n;
    logic clk_en;
    int   total;
    int   bad;
    int   lat;

    ahfp_add_seq_if bus ();

    ahfp_add_seq #(.ALIGN_LIMIT(25)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Presents operands for one edge; caller is #1 after a posedge.
    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dataa = 32'hDEAD_BEEF;
        bus.datab = 32'hDEAD_BEEF;
    endtask

    // Counts edges after the accept edge until done; optional clk_en stall and stray start pulse.
    task automatic wait_done(output int l, input int stall_at, input int pulse_at);
        l = 0;
        while (l < 300) begin
            clk_en = !(stall_at >= 0 && l >= stall_at && l < stall_at + 5);
            if (l == pulse_at) begin
                bus.start = 1'b1;
                bus.dataa = 32'h3F80_0000;
                bus.datab = 32'h3F80_0000;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            l++;
            if (bus.done) break;
        end
        clk_en = 1'b1;
        if (l >= 300) begin
            total++;
            bad++;
            $display("FAIL timeout observed=no_done expected=done");
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        clk_en    = 1'b1;
        bus.start = 1'b0;
        bus.dataa = 32'd0;
        bus.datab = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", bus.result, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        kick(32'h3F80_0000, 32'h3F80_0000);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, -1, -1);
        chk("one_plus_one", bus.result, 32'h4000_0000);
        chk("one_plus_one_lat", lat, 3);
        @(posedge clk);
        #1;
        chk("done_single_pulse", {31'd0, bus.done}, 32'd0);
        chk("result_held", bus.result, 32'h4000_0000);

        kick(32'h3F80_0000, 32'hBF40_0000);
        wait_done(lat, -1, -1);
        chk("one_minus_075", bus.result, 32'h3E80_0000);
        chk("one_minus_075_lat", lat, 6);

        kick(32'h4020_0000, 32'hC020_0000);
        wait_done(lat, -1, -1);
        chk("cancel_zero", bus.result, 32'h0000_0000);
        chk("cancel_zero_lat", lat, 3);

        kick(32'h7F7F_FFFF, 32'h7F7F_FFFF);
        wait_done(lat, -1, -1);
        chk("overflow_inf", bus.result, 32'h7F80_0000);
        chk("overflow_inf_lat", lat, 3);

        kick(32'h4B80_0000, 32'h3F80_0000);
        wait_done(lat, -1, -1);
        chk("d24_result", bus.result, 32'h4B80_0000);
        chk("d24_lat", lat, 27);

        kick(32'h4F80_0000, 32'h3F80_0000);
        wait_done(lat, -1, -1);
        chk("d32_result", bus.result, 32'h4F80_0000);
        chk("d32_lat", lat, 3);

        // Smaller operand in dataa and negative larger: sign follows the larger magnitude.
        kick(32'h3F40_0000, 32'hBF80_0000);
        wait_done(lat, -1, -1);
        chk("swap_neg", bus.result, 32'hBE80_0000);
        chk("swap_neg_lat", lat, 6);

        // Back-to-back: new start presented in the done cycle.
        kick(32'h3F80_0000, 32'h3F80_0000);
        wait_done(lat, -1, -1);
        chk("b2b_first", bus.result, 32'h4000_0000);
        kick(32'h3F80_0000, 32'hBF40_0000);
        chk("b2b_accepted_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, -1, -1);
        chk("b2b_second", bus.result, 32'h3E80_0000);
        chk("b2b_second_lat", lat, 6);

        // Start pulsed while busy must be dropped.
        kick(32'h4B80_0000, 32'h3F80_0000);
        wait_done(lat, -1, 5);
        chk("busy_start_result", bus.result, 32'h4B80_0000);
        chk("busy_start_lat", lat, 27);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_start_not_queued", {30'd0, bus.busy, bus.done}, 32'd0);

        // clk_en low for 5 edges in the middle of alignment.
        kick(32'h4B80_0000, 32'h3F80_0000);
        wait_done(lat, 4, -1);
        chk("stall_result", bus.result, 32'h4B80_0000);
        chk("stall_lat", lat, 32);

        // Async reset in NORM (1 - 0.75 is in NORM after edge 4).
        kick(32'h3F80_0000, 32'hBF40_0000);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_result", bus.result, 32'd0);
        chk("mid_rst_done_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
